pri_enc16to4_reg: RTL and testbench
===================================

// Module: pri_enc16to4_reg
// PURPOSE
//   Registered 16-to-4 priority encoder with request latching and a valid/ack handshake.
//   It is the inverse of the active-low 4-to-16 decoder tree.
//   Active-low one-of-N request lines are latched as sticky pending bits.
//   One pending index at a time is encoded onto code and held until the consumer acknowledges it.
//   Serves as the request-collection end of the decoder-driven select bus in the lab datapath.
// PARAMETERS
//   N_REQ   16                     number of request lines; power of 2, range 2..64
//   CODE_W  $clog2(N_REQ) (=4)     width of the encoded index
// PORTS
//   clk     in   1       rising-edge clock
//   rst     in   1       synchronous reset, active-high
//   En      in   1       capture/grant enable, active-high
//   D_n     in   [0:N_REQ-1]  request lines, active-low; D_n[k]=0 requests index k
//   ack     in   1       consumer accepts the presented code
//   code    out  [CODE_W-1:0]  encoded granted index
//   valid   out  1       code is valid and held stable
//   pend    out  [0:N_REQ-1]   pending-request register, active-high
// BEHAVIOUR
//   Reset: on any clk edge with rst=1:
//     - code=0, valid=0, pend=0, state=IDLE.
//     - Under ENC_ROUND_ROBIN_EN, ptr=N_REQ-1.
//     - rst overrides every other input, including mid-HOLD; a held grant is dropped without ack.
//   Capture, every edge, rst=0:
//     - pend_next = (pend & ~clr) | (En ? ~D_n : 0).
//     - clr is the one-hot of code when state=HOLD and ack=1, else 0.
//     - A request still low on the clearing edge re-sets its bit; set wins over clear.
//     - With En=0, pend only loses bits through clr.
//   FSM, 2 states:
//     - IDLE, valid=0:
//       - If En=1 and |pend, load code=sel(pend), set valid=1, go to HOLD.
//       - Otherwise stay in IDLE; code keeps its last value.
//     - HOLD, valid=1:
//       - code/valid are frozen regardless of D_n or En.
//       - On ack=1: clear pend[code], set valid=0, go to IDLE.
//   Selection sel(): lowest set index wins; index 0 has the highest priority.
//     - Selection uses the registered pend, not the raw D_n.
//   Latency:
//     - D_n[k] low at edge N sets pend[k] at edge N.
//     - code=k and valid=1 follow at edge N+1 (2 cycles from request to valid when starting in IDLE).
//   Throughput:
//     - One grant per 2 cycles minimum (HOLD->IDLE->HOLD).
//     - ack is sampled only in HOLD.
//   Boundaries:
//     - ack while valid=0 is ignored.
//     - A held request is re-pended and regranted after its ack; this is level semantics.
//     - All lines high with pend=0 leaves the FSM in IDLE indefinitely.
//     - A request on an index above code arriving during HOLD waits.
//     - A request on a lower index arriving during HOLD pre-empts at the next grant, never the current one.
// CONFIGURATION
//   ENC_ROUND_ROBIN_EN defined:
//     - sel() searches from (ptr+1) mod N_REQ upward with wrap-around.
//     - ptr<=code on each ack; ptr resets to N_REQ-1, so the first search starts at index 0.
//   ENC_ROUND_ROBIN_EN undefined:
//     - Fixed priority, index 0 highest; no ptr register exists.
// TESTING
//   1. Reset: rst=1 for 2 edges with D_n=16'h0000 -> code=0, valid=0, pend=0.
//   2. Single request: D_n[5]=0 for one cycle, En=1.
//      - pend[5]=1 next edge, then code=5, valid=1; valid holds for 10 cycles without ack.
//      - ack=1 -> valid=0, pend[5]=0.
//   3. Priority: D_n[3], D_n[9], D_n[12] pulsed low together, ack one cycle after each valid.
//      - Grant order is 3,9,12 in fixed mode.
//      - With ENC_ROUND_ROBIN_EN, start ptr=3: order is 9,12,3.
//   4. Hold stability: during HOLD code=9, pulse D_n[1]=0 -> code stays 9 until ack; next grant code=1.
//   5. Set-wins: D_n[7] held low through the ack edge -> pend[7] stays 1, code=7 regranted 2 cycles later.
//   6. En/reset: with En=0, pulse D_n[2]=0 -> pend stays 0, no grant.
//      - Mid-HOLD rst=1 -> valid=0, pend=0 next edge.
//      - Spurious ack in IDLE changes nothing.

Source files
------------

// File: rtl/pri_enc16to4_reg.sv
// Registered 16-to-4 priority encoder with sticky active-low request capture and valid/ack handshake.
// Define ENC_ROUND_ROBIN_EN to replace fixed priority with round-robin search after the last grant.
module pri_enc16to4_reg #(
    parameter int unsigned N_REQ  = 16,
    parameter int unsigned CODE_W = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              En,
    input  logic [0:N_REQ-1]  D_n,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [0:N_REQ-1]  pend
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [0:N_REQ-1]   pend_q, pend_d;
    logic [0:N_REQ-1]   clr;
    logic [CODE_W-1:0]  sel_idx;

`ifdef ENC_ROUND_ROBIN_EN
    logic [CODE_W-1:0]  ptr_q, ptr_d;

    // Descending walk over offsets so the nearest set bit after ptr is written last.
    always_comb begin
        sel_idx = '0;
        for (int unsigned i = N_REQ; i > 0; i--) begin
            logic [CODE_W-1:0] idx;
            idx = ptr_q + CODE_W'(1) + CODE_W'(i - 1);
            if (pend_q[idx]) begin
                sel_idx = idx;
            end
        end
    end
`else
    always_comb begin
        sel_idx = '0;
        for (int unsigned i = N_REQ; i > 0; i--) begin
            if (pend_q[i - 1]) begin
                sel_idx = CODE_W'(i - 1);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        clr     = '0;
`ifdef ENC_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (En && (|pend_q)) begin
                    code_d  = sel_idx;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ack) begin
                    clr[code_q] = 1'b1;
                    state_d     = S_IDLE;
`ifdef ENC_ROUND_ROBIN_EN
                    ptr_d       = code_q;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A request still asserted on the clearing edge re-pends its bit.
        pend_d = (pend_q & ~clr) | (En ? ~D_n : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            pend_q  <= '0;
`ifdef ENC_ROUND_ROBIN_EN
            ptr_q   <= CODE_W'(N_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pend_q  <= pend_d;
`ifdef ENC_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign code  = code_q;
    assign valid = (state_q == S_HOLD);
    assign pend  = pend_q;

endmodule

// File: tb/tb_pri_enc16to4_reg.sv
// Directed bench for pri_enc16to4_reg in its default fixed-priority build.
module tb_pri_enc16to4_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        En;
    logic [0:15] D_n;
    logic        ack;
    logic [3:0]  code;
    logic        valid;
    logic [0:15] pend;

    int checks = 0;
    int errors = 0;

    pri_enc16to4_reg #(.N_REQ(16), .CODE_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .En    (En),
        .D_n   (D_n),
        .ack   (ack),
        .code  (code),
        .valid (valid),
        .pend  (pend)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:15] bits(input int a, input int b = -1, input int c = -1);
        logic [0:15] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    initial begin
        rst = 1'b1; En = 1'b1; D_n = '0; ack = 1'b0;

        // 1. reset
        tick(); tick();
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_pend", 32'(pend), 32'd0);

        // 2. single request on index 5
        rst = 1'b0; D_n = '1;
        tick();
        chk("idle_nopend_valid", 32'(valid), 32'd0);
        D_n[5] = 1'b0;
        tick();
        chk("req5_pend", 32'(pend), 32'(bits(5)));
        chk("req5_valid_lat", 32'(valid), 32'd0);
        D_n = '1;
        tick();
        chk("req5_code", 32'(code), 32'd5);
        chk("req5_valid", 32'(valid), 32'd1);
        for (int i = 0; i < 10; i++) tick();
        chk("req5_hold_valid", 32'(valid), 32'd1);
        chk("req5_hold_code", 32'(code), 32'd5);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("req5_ack_valid", 32'(valid), 32'd0);
        chk("req5_ack_pend", 32'(pend), 32'd0);
        chk("idle_code_kept", 32'(code), 32'd5);

        // 3/4. priority 3,9,12 with index 1 arriving while 9 is held
        D_n[3] = 1'b0; D_n[9] = 1'b0; D_n[12] = 1'b0;
        tick();
        D_n = '1;
        chk("pri_pend", 32'(pend), 32'(bits(3, 9, 12)));
        tick();
        chk("pri_g1_code", 32'(code), 32'd3);
        chk("pri_g1_valid", 32'(valid), 32'd1);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("pri_g1_pend", 32'(pend), 32'(bits(9, 12)));
        tick();
        chk("pri_g2_code", 32'(code), 32'd9);
        D_n[1] = 1'b0;
        tick();
        D_n = '1;
        chk("hold_code_9a", 32'(code), 32'd9);
        chk("hold_pend", 32'(pend), 32'(bits(1, 9, 12)));
        tick();
        chk("hold_code_9b", 32'(code), 32'd9);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("pri_g2_pend", 32'(pend), 32'(bits(1, 12)));
        tick();
        chk("preempt_code_1", 32'(code), 32'd1);
        ack = 1'b1; tick(); ack = 1'b0;
        tick();
        chk("pri_g4_code", 32'(code), 32'd12);
        chk("pri_g4_valid", 32'(valid), 32'd1);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("pri_done_pend", 32'(pend), 32'd0);

        // 5. set wins over clear
        D_n[7] = 1'b0;
        tick(); tick();
        chk("sw_code", 32'(code), 32'd7);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("sw_valid_drop", 32'(valid), 32'd0);
        chk("sw_pend_kept", 32'(pend), 32'(bits(7)));
        tick();
        chk("sw_regrant_code", 32'(code), 32'd7);
        chk("sw_regrant_valid", 32'(valid), 32'd1);
        D_n = '1;
        ack = 1'b1; tick(); ack = 1'b0;
        chk("sw_release_pend", 32'(pend), 32'd0);

        // 6. En gating, mid-HOLD reset, spurious ack
        En = 1'b0; D_n[2] = 1'b0;
        tick();
        D_n = '1;
        chk("en0_pend", 32'(pend), 32'd0);
        tick();
        chk("en0_valid", 32'(valid), 32'd0);
        En = 1'b1; D_n[4] = 1'b0;
        tick();
        D_n = '1;
        tick();
        chk("pre_rst_code", 32'(code), 32'd4);
        rst = 1'b1; D_n[6] = 1'b0;
        tick();
        rst = 1'b0; D_n = '1;
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_pend", 32'(pend), 32'd0);
        chk("mid_rst_code", 32'(code), 32'd0);
        ack = 1'b1;
        tick(); tick();
        ack = 1'b0;
        chk("spur_ack_valid", 32'(valid), 32'd0);
        chk("spur_ack_pend", 32'(pend), 32'd0);
        chk("spur_ack_code", 32'(code), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
